maxpool2x2_stream: RTL and testbench

Streaming 2x2, stride-2 signed max-pool stage that sits directly downstream of the ReLU stage in the CNN datapath. It consumes one pixel per handshake in channel-major raster order and emits one pooled pixel per 2x2 window. A half-width line buffer holds row-pair partial maxima, so no full feature map is stored. Output order is channel-major raster at half resolution, ready for the next conv/flatten stage.

---
 rtl/maxpool2x2_stream.sv | 138 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over channel-major raster pixels.
// Row-pair partial maxima live in a half-width line buffer; one pooled pixel per window.
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 32,
    parameter int HEIGHT     = 28,
    parameter int WIDTH      = 28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last
);

    localparam int HALF_W   = WIDTH / 2;
    localparam int COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LB_IDX_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    if ((HEIGHT % 2) != 0) begin : g_height_odd
        $error("maxpool2x2_stream: HEIGHT must be even");
    end
    if ((WIDTH % 2) != 0) begin : g_width_odd
        $error("maxpool2x2_stream: WIDTH must be even");
    end

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]             col_r;
    logic [ROW_W-1:0]             row_r;
    logic [CH_W-1:0]              ch_r;
    logic signed [DATA_WIDTH-1:0] h_r;
    logic signed [DATA_WIDTH-1:0] lb_r [HALF_W];
    logic signed [DATA_WIDTH-1:0] out_data_r;
    logic                         out_valid_r;
    logic                         out_last_r;

    logic                         accept_s;
    logic                         load_s;
    logic                         col_last_s;
    logic                         row_last_s;
    logic                         ch_last_s;
    logic [LB_IDX_W-1:0]          lb_idx_s;
    logic signed [DATA_WIDTH-1:0] pair_max_s;
    logic signed [DATA_WIDTH-1:0] win_max_s;

    // A held output blocks new input until downstream takes it.
    assign in_ready  = !out_valid_r || out_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

    // Handshake, position decode and window maxima.
    always_comb begin
        accept_s   = in_valid && in_ready;
        col_last_s = (col_r == COL_W'(WIDTH - 1));
        row_last_s = (row_r == ROW_W'(HEIGHT - 1));
        ch_last_s  = (ch_r == CH_W'(CHANNELS - 1));
        lb_idx_s   = LB_IDX_W'(col_r >> 1);
        pair_max_s = smax(h_r, in_data);
        win_max_s  = smax(lb_r[lb_idx_s], pair_max_s);
        load_s     = accept_s && row_r[0] && col_r[0];
    end

    // Raster position counters: col, then row, then channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
            ch_r  <= {CH_W{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {COL_W{1'b0}};
                if (row_last_s) begin
                    row_r <= {ROW_W{1'b0}};
                    if (ch_last_s) begin
                        ch_r <= {CH_W{1'b0}};
                    end else begin
                        ch_r <= ch_r + CH_W'(1);
                    end
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
        end
    end

    // Left pixel of each horizontal pair waits in h until its partner arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s && !col_r[0]) begin
            h_r <= in_data;
        end else begin
            h_r <= h_r;
        end
    end

    // Even rows overwrite every line-buffer slot, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (!rst && accept_s && !row_r[0] && col_r[0]) begin
            lb_r[lb_idx_s] <= pair_max_s;
        end
    end

    // Output register: load on window close, otherwise clear once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_max_s;
            out_last_r  <= row_last_s && col_last_s && ch_last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Randomised and directed bench for maxpool2x2_stream (2 channels, 4x4 planes)
// with a frame-array reference model and an output scoreboard.
module tb_maxpool2x2_stream;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int FR = CH * H * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    int checks = 0;
    int errors = 0;
    int pix [FR];
    int acc_idx = 0;
    int exp_q [$];
    int expl_q [$];
    int obs_q [$];
    int obsl_q [$];
    bit lat_pending = 1'b0;
    int lat_expect = 0;
    bit rand_rdy = 1'b0;

    int std_out  [8] = '{5, 7, 13, 15, 105, 107, 113, 115};
    int std_last [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int sgn_out  [8] = '{-1, -128, -128, -128, -128, -128, -128, -128};

    maxpool2x2_stream #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .HEIGHT(H), .WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int r, c, m;
        if (rst) begin
            exp_q.delete();
            expl_q.delete();
            acc_idx = 0;
            lat_pending = 1'b0;
        end else begin
            if (lat_pending) check("latency", int'(out_valid), lat_expect);
            lat_pending = 1'b0;
            if (out_valid && out_ready) begin
                obs_q.push_back(int'($signed(out_data)));
                obsl_q.push_back(int'(out_last));
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    check("data", int'($signed(out_data)), exp_q.pop_front());
                    check("last", int'(out_last), expl_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                r = (acc_idx / W) % H;
                c = acc_idx % W;
                pix[acc_idx] = int'($signed(in_data));
                lat_expect = 0;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m = pix[acc_idx];
                    if (pix[acc_idx - 1] > m) m = pix[acc_idx - 1];
                    if (pix[acc_idx - W] > m) m = pix[acc_idx - W];
                    if (pix[acc_idx - W - 1] > m) m = pix[acc_idx - W - 1];
                    exp_q.push_back(m);
                    expl_q.push_back((acc_idx == FR - 1) ? 1 : 0);
                    lat_expect = 1;
                end
                lat_pending = 1'b1;
                acc_idx = (acc_idx + 1) % FR;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send(input int v, input bit gaps);
        int  n;
        bit  ok;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = v[DW-1:0];
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_std(input int first, input int last_px);
        for (int i = first; i <= last_px; i++) begin
            send((i < 16) ? i : 100 + i - 16, 1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", (n < 300) ? 1 : 0, 1);
    endtask

    task automatic check_std(input string tag, input int reps);
        check({tag, "_count"}, obs_q.size(), 8 * reps);
        for (int k = 0; k < obs_q.size() && k < 8 * reps; k++) begin
            check({tag, "_data"}, obs_q[k], std_out[k % 8]);
            check({tag, "_last"}, obsl_q[k], std_last[k % 8]);
        end
        obs_q.delete();
        obsl_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Two back-to-back frames of 0..15 / 100..115.
        send_std(0, 31);
        send_std(0, 31);
        drain();
        check_std("basic", 2);

        // Signed corner: all -128 except one -1 in the first window.
        for (int i = 0; i < FR; i++) send((i == 4) ? -1 : -128, 1'b0);
        drain();
        check("signed_count", obs_q.size(), 8);
        for (int k = 0; k < obs_q.size() && k < 8; k++) begin
            check("signed_data", obs_q[k], sgn_out[k]);
        end
        obs_q.delete();
        obsl_q.delete();

        // Backpressure as pooled value 5 appears.
        send_std(0, 5);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'd6;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), 5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_std(6, 31);
        drain();
        check_std("bp", 1);

        // Random data, random input gaps, random output backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FR; i++) send(int'($urandom_range(0, 255)), 1'b1);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check("rand_count", obs_q.size(), 32);
        obs_q.delete();
        obsl_q.delete();

        // Reset after 9 pixels, then a clean frame.
        send_std(0, 8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        obs_q.delete();
        obsl_q.delete();
        send_std(0, 31);
        drain();
        check_std("midrst", 1);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
